// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout is the borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (B & Bin) | (~A & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single cell.
// Handshake: start is sampled only in IDLE; busy is high for the WIDTH SHIFT
// cycles; done pulses for one cycle, and diff/borrow_out are valid from then on.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output state_e           state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // The bit shifted out of the bottom is never read, so only WIDTH-1 partial bits are kept.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             d_bit;
  logic             nb_bit;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_cell (
    .A    (op_a_q[0]),
    .B    (op_b_q[0]),
    .Bin  (brw_q),
    .Diff (d_bit),
    .Bout (nb_bit)
  );

  assign res_shift = {d_bit, res_q};

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          op_a_d  = a;
          op_b_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      SHIFT: begin
        res_d  = res_shift[WIDTH-1:1];
        op_a_d = op_a_q >> 1;
        op_b_d = op_b_q >> 1;
        brw_d  = nb_bit;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d   = res_shift;
          borrow_d = nb_bit;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random WIDTH=8 ops, exhaustive WIDTH=4 at full rate.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8 = 1'b1, start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  state_e     st8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .state_dbg(st8)
  );

  // WIDTH=4 instance
  logic       rst4 = 1'b1, start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;
  state_e     st4;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4), .state_dbg(st4)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_diff8 = '0;
  logic       last_brw8  = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, result wrapped to the width, borrow on unsigned underflow.
  function automatic logic [8:0] model(input int a, input int b, input int bi, input int w);
    int r;
    logic [31:0] rv;
    logic [8:0]  res;
    r   = a - b - bi;
    rv  = r;
    res = {8'd0, a < (b + bi)} << w;
    res = res | 9'(rv & ((32'd1 << w) - 32'd1));
    return res;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] e;
    int cyc, nbusy;
    e = model(int'(a), int'(b), int'(bi), 8);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    cyc = 0; nbusy = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) nbusy++;
      check("hold_diff", 32'(diff8), 32'(last_diff8));
      check("hold_borrow", 32'(borrow8), 32'(last_brw8));
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done8), 32'd1);
    check("busy_cycles", 32'(nbusy), 32'd8);
    check("diff", 32'(diff8), 32'(e[7:0]));
    check("borrow", 32'(borrow8), 32'(e[8]));
    last_diff8 = e[7:0];
    last_brw8  = e[8];
    @(negedge clk);
    check("done_one_cycle", 32'(done8), 32'd0);
    check("idle_after_done", 32'(busy8), 32'd0);
  endtask

  initial begin
    int cyc, ndone, nbusy;
    logic [8:0] e;

    // Reset
    rst8 = 1'b1; rst4 = 1'b1; start8 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(borrow8), 32'd0);
    check("rst_state", 32'(st8), 32'(IDLE));
    rst8 = 1'b0; rst4 = 1'b0; start8 = 1'b0;

    // Basic op, then hold check on the following op
    run8(8'h35, 8'h12, 1'b0);
    run8(8'h10, 8'h01, 1'b0);
    run8(8'h12, 8'h35, 1'b0);
    run8(8'h00, 8'h00, 1'b1);
    run8(8'hFF, 8'hFF, 1'b1);
    run8(8'h00, 8'h01, 1'b0);

    // start pulses while busy and during DONE are ignored
    e = model(32'h80, 32'h01, 0, 8);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1; a8 = 8'h00;
    @(negedge clk); start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_done_seen", 32'(done8), 32'd1);
    check("ign_diff", 32'(diff8), 32'(e[7:0]));
    check("ign_borrow", 32'(borrow8), 32'(e[8]));
    start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      if (busy8) nbusy++;
      @(negedge clk);
    end
    check("ign_extra_done", 32'(ndone), 32'd0);
    check("ign_extra_busy", 32'(nbusy), 32'd0);
    last_diff8 = e[7:0]; last_brw8 = e[8];

    // Reset in the 4th SHIFT cycle, with start held alongside
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1; start8 = 1'b1;
    @(negedge clk); rst8 = 1'b0; start8 = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_borrow", 32'(borrow8), 32'd0);
    check("abort_state", 32'(st8), 32'(IDLE));
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      if (busy8) nbusy++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_no_busy", 32'(nbusy), 32'd0);
    last_diff8 = '0; last_brw8 = 1'b0;
    run8(8'h35, 8'h12, 1'b0);

    // Random ops
    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)));

    // WIDTH=4 exhaustive, back-to-back at one op per WIDTH+2 cycles
    @(negedge clk);
    for (int x = 0; x < 512; x++) begin
      a4 = x[3:0]; b4 = x[7:4]; bin4 = x[8];
      exp_q.push_back(model(int'(x[3:0]), int'(x[7:4]), int'(x[8]), 4));
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      cyc = 1;
      while (!done4 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("w4_latency", 32'(cyc), 32'd5);
      if (exp_q.size() == 0) check("w4_queue", 32'd0, 32'd1);
      else check("w4_result", 32'({4'd0, borrow4, diff4}), 32'(exp_q.pop_front()));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
